// File: rtl/nn_pkg.sv
// Shared types and helpers for the output-layer argmax sequencer.
package nn_pkg;

   localparam int DIGIT_W = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCUM  = 2'd1,
      RESULT = 2'd2
   } state_e;

   function automatic logic [31:0] most_neg(input int res);
      most_neg = 32'd1 << (res - 1);
   endfunction

endpackage

// File: rtl/argmax_accum.sv
// Running signed maximum and its index; ties go to the later sample.
module argmax_accum
   import nn_pkg::*;
#(
   parameter int resolution = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          load_i,
   input  logic                          en_i,
   input  logic signed [resolution-1:0]  data_i,
   input  logic [DIGIT_W-1:0]            idx_i,
   output logic signed [resolution-1:0]  max_nxt_o,
   output logic [DIGIT_W-1:0]            idx_nxt_o
);

   typedef logic signed [resolution-1:0] act_t;

   localparam act_t MNEG = act_t'(most_neg(resolution));

   act_t               max_q, max_d;
   logic [DIGIT_W-1:0] idx_q, idx_d;
   logic               take;

   assign take = en_i && (data_i >= max_q);

   always_comb begin
      max_d = max_q;
      idx_d = idx_q;
      if (load_i) begin
         max_d = MNEG;
         idx_d = '0;
      end else if (take) begin
         max_d = data_i;
         idx_d = idx_i;
      end
   end

   // The caller captures the result in the same cycle as the last sample.
   assign max_nxt_o = max_d;
   assign idx_nxt_o = idx_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         max_q <= MNEG;
         idx_q <= '0;
      end else begin
         max_q <= max_d;
         idx_q <= idx_d;
      end
   end

endmodule

// File: rtl/prediction_sequencer.sv
// Streams output-layer activations, reports argmax digit via valid/ready.
module prediction_sequencer
   import nn_pkg::*;
#(
   parameter int neuron_number = 10,
   parameter int resolution    = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          start,
   input  logic                          abort,
   input  logic                          act_valid,
   input  logic signed [resolution-1:0]  act_data,
   output logic                          act_ready,
   output logic                          result_valid,
   input  logic                          result_ready,
   output logic [DIGIT_W-1:0]            predicted_digit,
   output logic signed [resolution-1:0]  max_activation,
   output logic                          busy
);

   if (neuron_number < 2 || neuron_number > 16) begin : g_bad_n
      $error("neuron_number must be within 2..16");
   end

   localparam logic [DIGIT_W-1:0] LAST = DIGIT_W'(neuron_number - 1);

   state_e                        state_q, state_d;
   logic [DIGIT_W-1:0]            count_q, count_d;
   logic [DIGIT_W-1:0]            digit_q, digit_d;
   logic signed [resolution-1:0]  maxact_q, maxact_d;
   logic                          load, accept;
   logic signed [resolution-1:0]  max_nxt;
   logic [DIGIT_W-1:0]            idx_nxt;

   argmax_accum #(
      .resolution (resolution)
   ) u_accum (
      .clk       (clk),
      .rst_n     (rst_n),
      .load_i    (load),
      .en_i      (accept),
      .data_i    (act_data),
      .idx_i     (count_q),
      .max_nxt_o (max_nxt),
      .idx_nxt_o (idx_nxt)
   );

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      digit_d  = digit_q;
      maxact_d = maxact_q;
      load     = 1'b0;
      accept   = 1'b0;
      // Abort outranks every other request in the same cycle.
      if (abort) begin
         state_d = IDLE;
         count_d = '0;
         load    = 1'b1;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  load    = 1'b1;
                  count_d = '0;
                  state_d = ACCUM;
               end
            end
            ACCUM: begin
               if (act_valid) begin
                  accept  = 1'b1;
                  count_d = count_q + 1'b1;
                  if (count_q == LAST) begin
                     digit_d  = idx_nxt;
                     maxact_d = max_nxt;
                     state_d  = RESULT;
                  end
               end
            end
            RESULT: begin
               if (result_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign act_ready       = (state_q == ACCUM);
   assign result_valid    = (state_q == RESULT);
   assign busy            = (state_q != IDLE);
   assign predicted_digit = digit_q;
   assign max_activation  = maxact_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         count_q  <= '0;
         digit_q  <= '0;
         maxact_q <= '0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         digit_q  <= digit_d;
         maxact_q <= maxact_d;
      end
   end

endmodule

// File: tb/tb_prediction_sequencer.sv
// Randomized and directed bench for prediction_sequencer with argmax model.
module tb_prediction_sequencer;

   localparam int N = 10;
   localparam int R = 8;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 start = 1'b0;
   logic                 abort = 1'b0;
   logic                 act_valid = 1'b0;
   logic signed [R-1:0]  act_data = '0;
   logic                 act_ready;
   logic                 result_valid;
   logic                 result_ready = 1'b0;
   logic [3:0]           predicted_digit;
   logic signed [R-1:0]  max_activation;
   logic                 busy;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;
   int fv[N];
   int exp_digit = 0;
   int exp_max   = 0;

   prediction_sequencer #(
      .neuron_number (N),
      .resolution    (R)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .start           (start),
      .abort           (abort),
      .act_valid       (act_valid),
      .act_data        (act_data),
      .act_ready       (act_ready),
      .result_valid    (result_valid),
      .result_ready    (result_ready),
      .predicted_digit (predicted_digit),
      .max_activation  (max_activation),
      .busy            (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference: largest value first, then the last index holding it.
   task automatic model();
      int mx;
      mx = -1000;
      for (int i = 0; i < N; i++) if (fv[i] > mx) mx = fv[i];
      for (int i = 0; i < N; i++) if (fv[i] == mx) exp_digit = i;
      exp_max = mx;
   endtask

   task automatic check_outs(input string tag);
      check({tag, "_dig"}, int'(predicted_digit), exp_digit);
      check({tag, "_max"}, int'(max_activation), exp_max);
   endtask

   task automatic run_frame(input bit gaps, input int hold,
                            input int start_at, input int abort_at);
      int c0;
      start = 1'b1;
      step();
      start = 1'b0;
      c0 = cyc;
      check("busy_go", int'(busy), 1);
      for (int i = 0; i < N; i++) begin
         while (gaps && $urandom_range(0, 2) == 0) begin
            act_valid = 1'b0;
            act_data  = R'($urandom);
            step();
            check("rdy_gap", int'(act_ready), 1);
         end
         if (i == abort_at) begin
            abort     = 1'b1;
            start     = 1'b1;
            act_valid = 1'b1;
            act_data  = 8'sd127;
            step();
            abort     = 1'b0;
            start     = 1'b0;
            act_valid = 1'b0;
            check("ab_rv", int'(result_valid), 0);
            check("ab_busy", int'(busy), 0);
            check("ab_rdy", int'(act_ready), 0);
            check_outs("ab");
            repeat (N + 2) step();
            check("ab_rv2", int'(result_valid), 0);
            check_outs("ab2");
            return;
         end
         act_valid = 1'b1;
         act_data  = R'(fv[i]);
         start     = (i == start_at);
         #1;
         check("rdy", int'(act_ready), 1);
         check("rv_early", int'(result_valid), 0);
         step();
         start = 1'b0;
      end
      act_valid = 1'b0;
      model();
      check("rv", int'(result_valid), 1);
      check_outs("res");
      if (!gaps) check("latency", cyc - c0, N);
      result_ready = 1'b0;
      for (int k = 0; k < hold; k++) begin
         step();
         check("hold_rv", int'(result_valid), 1);
         check("hold_rdy", int'(act_ready), 0);
         check_outs("hold");
      end
      result_ready = 1'b1;
      start        = 1'b1;
      #1;
      check("hs_rv", int'(result_valid), 1);
      step();
      result_ready = 1'b0;
      start        = 1'b0;
      check("done_rv", int'(result_valid), 0);
      check("done_busy", int'(busy), 0);
      check_outs("done");
      step();
      check("idle_busy", int'(busy), 0);
   endtask

   initial begin
      #12;
      check("rst_rv", int'(result_valid), 0);
      check("rst_rdy", int'(act_ready), 0);
      check("rst_busy", int'(busy), 0);
      check_outs("rst");
      rst_n = 1'b1;
      step();

      // Basic frame
      fv = '{5, -3, 20, 7, 0, 1, -128, 19, 2, 4};
      run_frame(1'b0, 0, -1, -1);
      check("basic_dig", exp_digit, 2);

      // All most-negative: tie resolves to last index
      for (int i = 0; i < N; i++) fv[i] = -128;
      run_frame(1'b0, 1, -1, -1);
      check("neg_dig", int'(predicted_digit), 9);

      // Equal maxima at 3 and 6
      fv = '{1, -5, 12, 40, 39, -40, 40, 0, 7, 3};
      run_frame(1'b0, 0, -1, -1);
      check("tie_dig", int'(predicted_digit), 6);

      // Stalls and long result backpressure
      for (int i = 0; i < N; i++) fv[i] = int'($urandom_range(0, 255)) - 128;
      run_frame(1'b1, 5, -1, -1);

      // Frame A wins at 7, then frame B aborted after 4 accepts
      fv = '{1, 2, 3, 4, 5, 6, 7, 90, 8, 9};
      run_frame(1'b0, 0, -1, -1);
      check("a_dig", int'(predicted_digit), 7);
      for (int i = 0; i < N; i++) fv[i] = 100;
      run_frame(1'b0, 0, -1, 4);
      check("b_dig", int'(predicted_digit), 7);
      fv = '{-9, 3, 77, -1, 76, 0, 0, 12, 5, -100};
      run_frame(1'b0, 2, -1, -1);

      // start pulse mid-frame is ignored
      fv = '{10, 20, 30, 40, 50, 60, 55, 45, 35, 25};
      run_frame(1'b0, 0, 5, -1);

      // Async reset between edges, mid-ACCUM
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         act_valid = 1'b1;
         act_data  = 8'sd60;
         step();
      end
      act_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      exp_digit = 0;
      exp_max   = 0;
      check("ar_busy", int'(busy), 0);
      check("ar_rdy", int'(act_ready), 0);
      check("ar_rv", int'(result_valid), 0);
      check_outs("ar");
      step();
      #2 rst_n = 1'b1;
      step();
      for (int i = 0; i < N; i++) fv[i] = int'($urandom_range(0, 255)) - 128;
      run_frame(1'b0, 0, -1, -1);

      // Random frames
      for (int f = 0; f < 30; f++) begin
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 3) == 0) fv[i] = 40;
            else fv[i] = int'($urandom_range(0, 255)) - 128;
         end
         run_frame(1'($urandom_range(0, 1)), int'($urandom_range(0, 4)),
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, N - 1)) : -1,
                   ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, N - 1)) : -1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/prediction_sequencer.md
Name: prediction_sequencer

Overview:
- Sequential argmax controller for the output layer.
- Accepts the `neuron_number` signed output activations one per handshake, tracks the running maximum and its index, and presents the predicted digit with a valid/ready result handshake.
- Sits between the output-layer neuron scheduler, which streams activations, and the display/UART consumer.
- Holds the last prediction stable for the 7-segment driver between inferences.

Parameters:
- neuron_number, 10, number of activations per inference (2..16).
- resolution, 8, activation width in bits, two's complement.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a new inference frame.
- abort  in  1  synchronous frame cancel.
- act_valid  in  1  act_data is valid this cycle.
- act_data  in  resolution  signed activation; neuron index is implicit (arrival order 0..N-1).
- act_ready  out  1  sequencer accepts act_data this cycle.
- result_valid  out  1  prediction available.
- result_ready  in  1  consumer takes the prediction.
- predicted_digit  out  4  argmax index of the last completed frame.
- max_activation  out  resolution  signed winning activation value.
- busy  out  1  high in ACCUM or RESULT.

Behaviour:
- Reset (rst_n low, asynchronous), all outputs and registers cleared:
  - state=IDLE
  - act_ready=0, result_valid=0, busy=0
  - predicted_digit=0, max_activation=0
  - count=0, run_max=most negative value (1 followed by zeros), run_idx=0
- States: IDLE, ACCUM, RESULT.
- IDLE:
  - On start=1: load run_max=most negative, run_idx=0, count=0; next state ACCUM.
  - act_ready=0, result_valid=0.
- ACCUM:
  - act_ready=1.
  - Accept when act_valid & act_ready.
  - On accept, compare signed act_data >= run_max. If true, run_max=act_data and run_idx=count. Ties therefore go to the higher index.
  - count increments on accept.
  - On the accept where count==neuron_number-1: register predicted_digit=final idx and max_activation=final max; next state RESULT.
  - No accept means no change; stalls of any length are legal.
- RESULT:
  - result_valid=1, act_ready=0.
  - On result_ready=1: next state IDLE; result_valid drops the following cycle.
  - predicted_digit and max_activation are held until the next frame completes, including through IDLE.
- Latency:
  - start at cycle T gives act_ready=1 from T+1.
  - Last accept at cycle L gives result_valid=1 and updated outputs at L+1.
  - With act_valid held high, N=10 gives result_valid at T+11.
- start is ignored in ACCUM and RESULT.
- A start in the same cycle as the RESULT handshake is ignored; it must be reissued from IDLE.
- abort, from any state, next cycle:
  - state=IDLE; count and run registers re-initialised.
  - predicted_digit and max_activation keep their previous completed values.
  - result_valid=0 even if RESULT had not handshaken.
  - abort has priority over start, accept and result_ready in the same cycle.
- Arithmetic:
  - Comparisons are signed, resolution bits; no extension needed.
  - count is 4 bits; neuron_number>16 or <2 is illegal, enforced by an elaboration-time check.
- busy = (state != IDLE).
- Reset asserted mid-frame returns everything to reset values immediately; no partial result is emitted.

Decomposition:
- Shared package (nn_pkg):
  - state encoding constants IDLE/ACCUM/RESULT
  - DIGIT_W=4
  - function for the most-negative value of a given resolution
- One natural sub-module: argmax_accum, holding run_max/run_idx registers and the signed >= compare with load/enable inputs.
- FSM, counter and handshakes stay in prediction_sequencer.

Test Plan:
- Basic frame: start; stream 5,-3,20,7,0,1,-128,19,2,4 with act_valid always high → result_valid at start+11, predicted_digit=2, max_activation=20.
- Tie and negatives:
  - Frame all -128 → digit 9, max -128.
  - Frame with 40 at indices 3 and 6, rest smaller → digit 6.
- Backpressure and stalls: random act_valid gaps, then result_ready held low 5 cycles → result_valid stays high with outputs stable; drops the cycle after result_ready=1; act_ready=0 throughout RESULT.
- Abort:
  - Abort after 4 accepts of frame B, following a completed frame A (digit 7) → IDLE, result_valid never asserts, predicted_digit stays 7.
  - A new frame then completes correctly.
- Ignored start: pulse start during ACCUM at count=5 → count unaffected, frame completes normally with correct argmax.
- Async reset: assert rst_n low mid-ACCUM, between clock edges → outputs zero immediately; after release, a full frame yields the correct digit.
